// File: rtl/timer_pkg.sv
// Shared definitions for the programmable timer: register map,
// CTRL/STATUS bit positions and FSM state encoding.
package timer_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_LOAD   = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_PERIODIC  = 1;
    localparam int CTRL_IRQ_EN    = 2;
    localparam int STATUS_PENDING = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tmr_downcnt.sv
// Loadable down-counter; load has priority over decrement.
// zero flags a count of 0 from the register itself.
module tmr_downcnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/prog_timer.sv
// Programmable down-counting timer with one-shot/periodic modes,
// CPU register file and level interrupt.
module prog_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [1:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             irq
);

    state_t           state;
    state_t           state_next;
    logic             en;
    logic             periodic;
    logic             irq_en;
    logic             pending;
    logic [WIDTH-1:0] load_reg;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             cnt_load;
    logic             cnt_dec;
    logic             expire;
    logic             ctrl_wr;
    logic             load_wr;
    logic             status_wr;
    logic             wr_en_bit;

    assign ctrl_wr   = wr_en && (wr_addr == ADDR_CTRL);
    assign load_wr   = wr_en && (wr_addr == ADDR_LOAD);
    assign status_wr = wr_en && (wr_addr == ADDR_STATUS);
    assign wr_en_bit = wr_data[CTRL_EN];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A CTRL write always wins over a coincident tick.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ctrl_wr && wr_en_bit) state_next = RUN;
            end
            RUN: begin
                if (ctrl_wr) begin
                    if (!wr_en_bit) state_next = IDLE;
                end else if (tick && zero && !periodic) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (ctrl_wr) state_next = wr_en_bit ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        expire   = 1'b0;
        case (state)
            RUN: begin
                if (!ctrl_wr && tick) begin
                    if (zero) begin
                        expire   = 1'b1;
                        cnt_load = periodic;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: cnt_load = ctrl_wr && wr_en_bit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            irq_en   <= 1'b0;
            load_reg <= '0;
            pending  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en       <= wr_data[CTRL_EN];
                periodic <= wr_data[CTRL_PERIODIC];
                irq_en   <= wr_data[CTRL_IRQ_EN];
            end else if (expire && !periodic) begin
                en <= 1'b0;
            end
            if (load_wr) load_reg <= wr_data;
            // Expiry beats a same-edge STATUS clear.
            if (expire) begin
                pending <= 1'b1;
            end else if (status_wr && wr_data[STATUS_PENDING]) begin
                pending <= 1'b0;
            end
        end
    end

    tmr_downcnt #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (load_reg),
        .count    (count),
        .zero     (zero)
    );

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_CTRL:   rd_data[2:0] = {irq_en, periodic, en};
            ADDR_LOAD:   rd_data = load_reg;
            ADDR_COUNT:  rd_data = count;
            ADDR_STATUS: rd_data[STATUS_PENDING] = pending;
            default:     rd_data = '0;
        endcase
    end

    assign irq = pending & irq_en;

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: directed register reads queue
// hand-computed expectations, a negedge monitor compares them.
module tb_prog_timer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick = 1'b0;
    logic         wr_en = 1'b0;
    logic [1:0]   wr_addr = 2'd0;
    logic [W-1:0] wr_data = '0;
    logic [1:0]   rd_addr = 2'd0;
    logic [W-1:0] rd_data;
    logic         irq;

    typedef struct {
        logic [W-1:0] data;
        logic         irq;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    logic obs = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    prog_timer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (obs) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL underflow: no expected entry, rd_data=%0h irq=%0b",
                         rd_data, irq);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rd_data !== e.data || irq !== e.irq) begin
                    miscompares++;
                    $display("FAIL %s: got data=%0d irq=%0b, want data=%0d irq=%0b",
                             e.name, rd_data, irq, e.data, e.irq);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic w, input logic [1:0] a,
                         input logic [W-1:0] d, input logic t);
        wr_en   = w;
        wr_addr = a;
        wr_data = d;
        tick    = t;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, '0, 1'b1);
    endtask

    task automatic chk(input logic [1:0] a, input logic [W-1:0] d,
                       input logic i, input string name);
        exp_t e;
        e.data = d;
        e.irq  = i;
        e.name = name;
        exp_q.push_back(e);
        rd_addr = a;
        obs = 1'b1;
        @(negedge clk);
        #1;
        obs = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk(2'd0, 0, 0, "rst_ctrl");
        chk(2'd1, 0, 0, "rst_load");
        chk(2'd2, 0, 0, "rst_count");
        chk(2'd3, 0, 0, "rst_status");

        // one-shot, LOAD=3
        drive(1, 2'd1, 3, 0);
        drive(1, 2'd0, 5, 0);
        chk(2'd2, 3, 0, "os_cnt3");
        ticks(1);
        chk(2'd2, 2, 0, "os_cnt2");
        ticks(1);
        chk(2'd2, 1, 0, "os_cnt1");
        ticks(1);
        chk(2'd2, 0, 0, "os_cnt0");
        ticks(1);
        chk(2'd0, 4, 1, "os_ctrl_done");
        chk(2'd3, 1, 1, "os_pending");
        ticks(1);
        chk(2'd2, 0, 1, "os_done_hold");
        drive(1, 2'd3, 1, 0);
        chk(2'd3, 0, 0, "os_clear");

        // periodic, LOAD=2
        drive(1, 2'd1, 2, 0);
        drive(1, 2'd0, 7, 0);
        ticks(3);
        chk(2'd3, 1, 1, "per_exp1");
        chk(2'd2, 2, 1, "per_reload1");
        drive(1, 2'd3, 1, 0);
        chk(2'd3, 0, 0, "per_clear");
        ticks(2);
        chk(2'd3, 0, 0, "per_mid");
        ticks(1);
        chk(2'd3, 1, 1, "per_exp2");

        // expiry tick with same-edge STATUS clear
        ticks(2);
        drive(1, 2'd3, 1, 1);
        chk(2'd3, 1, 1, "set_beats_clr");
        chk(2'd2, 2, 1, "clr_reload");
        // tick with same-edge CTRL write is dropped
        drive(1, 2'd0, 7, 1);
        chk(2'd2, 2, 1, "ctrl_drops_tick");
        chk(2'd0, 7, 1, "ctrl_run_rd");

        // LOAD rewrite mid-count
        drive(1, 2'd3, 1, 0);
        drive(1, 2'd0, 0, 0);
        drive(1, 2'd1, 5, 0);
        drive(1, 2'd0, 3, 0);
        ticks(2);
        chk(2'd2, 3, 0, "ld_cnt3");
        drive(1, 2'd1, 1, 0);
        chk(2'd2, 3, 0, "ld_undisturbed");
        ticks(3);
        chk(2'd3, 0, 0, "ld_no_exp_yet");
        ticks(1);
        chk(2'd3, 1, 0, "ld_exp_6ticks");
        chk(2'd2, 1, 0, "ld_new_reload");
        drive(1, 2'd3, 1, 0);
        ticks(1);
        chk(2'd3, 0, 0, "ld_short_mid");
        ticks(1);
        chk(2'd3, 1, 0, "ld_exp_2ticks");

        // LOAD=0 periodic expires every tick
        drive(1, 2'd0, 0, 0);
        drive(1, 2'd1, 0, 0);
        drive(1, 2'd3, 1, 0);
        drive(1, 2'd0, 3, 0);
        ticks(1);
        chk(2'd3, 1, 0, "l0_exp1");
        drive(1, 2'd3, 1, 0);
        chk(2'd3, 0, 0, "l0_clear");
        ticks(1);
        chk(2'd3, 1, 0, "l0_exp2");

        // reset mid-count at COUNT=4
        drive(1, 2'd0, 0, 0);
        drive(1, 2'd3, 1, 0);
        drive(1, 2'd1, 4, 0);
        drive(1, 2'd0, 7, 0);
        chk(2'd2, 4, 0, "pre_rst_cnt");
        rst  = 1'b1;
        tick = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        tick = 1'b0;
        chk(2'd2, 0, 0, "rst_mid_count");
        chk(2'd0, 0, 0, "rst_mid_ctrl");
        chk(2'd1, 0, 0, "rst_mid_load");
        chk(2'd3, 0, 0, "rst_mid_status");
        ticks(2);
        chk(2'd2, 0, 0, "rst_idle_ticks");
        chk(2'd3, 0, 0, "rst_idle_status");

        @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: %0d expected entries not checked, want 0",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_timer.md
# prog_timer

Programmable down-counting timer driven by the single-cycle tick pulse of the system prescaler counter. It provides CPU-visible control, reload, live-count and status registers, supports one-shot and periodic modes, and raises a level interrupt toward the CPU interrupt logic. It sits directly downstream of the prescaler, taking the prescaler's carry as its `tick` input, and is mapped into the CPU peripheral register space.

## Interface
- `WIDTH`, 16: width of the LOAD and COUNT registers and of `wr_data`/`rd_data`.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `tick`  in  1  one-cycle pulse from the prescaler carry; may be high on consecutive cycles.
- `wr_en`  in  1  register write strobe, single cycle.
- `wr_addr`  in  2  write register select.
- `wr_data`  in  WIDTH  write data.
- `rd_addr`  in  2  read register select.
- `rd_data`  out  WIDTH  combinational read data; unused bits are zero.
- `irq`  out  1  interrupt level, equal to `pending & irq_en`.

## Operation
- Register map:
  - addr 0 CTRL: [0] `en`, [1] `periodic`, [2] `irq_en`.
  - addr 1 LOAD: reload value.
  - addr 2 COUNT: read-only; writes are ignored.
  - addr 3 STATUS: [0] `pending`; writing 1 clears it, writing 0 has no effect.
- Reset value of every register, of `pending` and of `irq` is 0. The state machine resets to IDLE.
- States: IDLE, RUN, DONE.
- IDLE → RUN: CTRL write with `en`=1. COUNT←LOAD in the same edge.
- RUN → IDLE: CTRL write with `en`=0. COUNT holds its value.
- RUN, `tick`=1:
  - COUNT≠0: COUNT←COUNT−1.
  - COUNT=0 and periodic: `pending`←1, COUNT←LOAD, stay in RUN.
  - COUNT=0 and one-shot: `pending`←1, CTRL.`en`←0, go to DONE.
- DONE → RUN: CTRL write with `en`=1 reloads COUNT from LOAD.
- DONE → IDLE: CTRL write with `en`=0.
- Expiry period is LOAD+1 ticks. LOAD=0 in periodic mode sets `pending` on every tick.
- A CTRL write with `en`=1 while in RUN updates only the `periodic` and `irq_en` bits. It does not restart the count.
- A LOAD write during RUN takes effect at the next reload only; COUNT is not disturbed.
- Arithmetic is unsigned WIDTH-bit. COUNT never wraps below 0 because expiry reloads or stops the count.

## Timing
- `tick` is sampled on the rising edge of `clk`. The COUNT update is visible on `rd_data` the cycle after the tick.
- `irq` rises the cycle after the expiring tick edge. It is a function of flops only, with no combinational path from inputs.
- A STATUS clear drops `irq` the cycle after the write.
- Simultaneous events:
  - Expiry and STATUS clear on the same edge: the set wins, so `pending` stays 1.
  - CTRL write and tick on the same edge: the write takes effect and the tick is dropped.
  - LOAD write and reload on the same edge: the old LOAD value is reloaded.
- `rst` mid-count returns everything to reset values on that edge. Ticks during `rst` are ignored.

## Structure
- Shared package `timer_pkg` holds:
  - the register address constants;
  - the CTRL/STATUS bit indices;
  - the state enum `{IDLE, RUN, DONE}`.
- One natural sub-module: `tmr_downcnt`, a WIDTH-bit loadable down-counter with `load`, `dec` and `zero` outputs. The FSM and register file live in `prog_timer`.
- The prescaler stays a separate instance in the parent; its carry output connects to `tick`.

## Test plan
- Reset then read all four addresses → all read 0, `irq`=0.
- LOAD=3, CTRL=0b101 (one-shot, irq_en), tick every cycle → COUNT reads 3,2,1,0; `irq`=1 one cycle after the 4th tick; state DONE; CTRL reads 0b100.
- LOAD=2, CTRL=0b111, continuous ticks → `pending` set every 3 ticks; clear via STATUS=1; the next expiry re-asserts `irq`.
- Periodic, LOAD=5: write LOAD=1 mid-count → the current period completes with 6 ticks, following periods take 2 ticks.
- Expiry tick coincident with STATUS clear write → `pending` stays 1; tick coincident with CTRL write → COUNT unchanged by that tick.
- Assert `rst` at COUNT=4 in RUN → next cycle all registers 0, `irq`=0, ticks ignored until re-enabled.
